// File: rtl/clk_div_ctrl.sv
// Programmable power-of-two clock divider.
// clk_out has half-period 2^cur_sel clk_in cycles. A new selection is handed over
// with a sel_req/sel_ack handshake and only takes effect at a period boundary,
// so no shortened phase is ever produced by a selection change.
module clk_div_ctrl #(
    parameter int unsigned DEFAULT_SEL = 17,
    parameter int unsigned MAX_SEL     = 17
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] div_sel,
    input  logic       sel_req,
    output logic       sel_ack,
    output logic       clk_out,
    output logic       tick,
    output logic       busy,
    output logic [4:0] cur_sel
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SWITCH,
        STOP
    } state_t;

    state_t      state;
    logic [16:0] cnt;
    logic [4:0]  pending;
    logic [17:0] limit;
    logic [4:0]  sel_sat;
    logic        tc;
    logic        latch_req;
    logic        apply_sw;

    // Terminal count, saturated request value and handshake qualifiers.
    always_comb begin
        limit     = (18'd1 << cur_sel) - 18'd1;
        tc        = ({1'b0, cnt} == limit);
        sel_sat   = (div_sel > 5'(MAX_SEL)) ? 5'(MAX_SEL) : div_sel;
        // The requester still holds sel_req during the sel_ack cycle; that
        // cycle must not be taken as a fresh request.
        latch_req = sel_req && !busy && !sel_ack;
        // A pending selection is applied when a high phase ends, i.e. at the
        // close of a full low+high period.
        apply_sw  = tc && clk_out && busy;
    end

    // Control FSM, half-period counter, divided clock and handshake registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            sel_ack <= 1'b0;
            busy    <= 1'b0;
            pending <= 5'(DEFAULT_SEL);
            cur_sel <= 5'(DEFAULT_SEL);
        end else begin
            tick    <= 1'b0;
            sel_ack <= 1'b0;

            if (latch_req) begin
                pending <= sel_sat;
                busy    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    // Nothing is running, so a latched selection applies at once.
                    if (busy) begin
                        cur_sel <= pending;
                        sel_ack <= 1'b1;
                        busy    <= 1'b0;
                    end
                    if (en) begin
                        state <= RUN;
                    end
                end

                default: begin
                    if (!en && !clk_out) begin
                        // Stopping in the low phase: cut it short, never start a high pulse.
                        state   <= IDLE;
                        cnt     <= '0;
                        clk_out <= 1'b0;
                    end else begin
                        if (tc) begin
                            cnt     <= '0;
                            clk_out <= ~clk_out;
                            tick    <= ~clk_out;
                            if (apply_sw) begin
                                cur_sel <= pending;
                                sel_ack <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 17'd1;
                        end

                        // Disabled with clk_out high: finish the high phase in STOP,
                        // then fall to IDLE on its terminal count.
                        if (!en) begin
                            state <= tc ? IDLE : STOP;
                        end else if ((busy && !apply_sw) || latch_req) begin
                            state <= SWITCH;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset values, selection handshake, divide
// ratios, enable drop in both phases, STOP resume, saturation and async reset.
module tb_clk_div_ctrl;

    logic       clk_in;
    logic       rst;
    logic       en;
    logic [4:0] div_sel;
    logic       sel_req;
    logic       sel_ack;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [4:0] cur_sel;

    int n_total = 0;
    int n_bad   = 0;

    clk_div_ctrl #(
        .DEFAULT_SEL(17),
        .MAX_SEL    (17)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .div_sel(div_sel),
        .sel_req(sel_req),
        .sel_ack(sel_ack),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy),
        .cur_sel(cur_sel)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one clk_in rising edge and settle just after it.
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Run n cycles expecting clk_out constant.
    task automatic expect_phase(input string tag, input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            check(tag, 32'(clk_out), 32'(val));
        end
    endtask

    // Request a selection from IDLE and complete the handshake.
    task automatic idle_select(input string tag, input logic [4:0] sel, input logic [4:0] exp_sel);
        sel_req = 1'b1;
        div_sel = sel;
        cyc();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_noack"}, 32'(sel_ack), 32'd0);
        cyc();
        check({tag, "_ack"}, 32'(sel_ack), 32'd1);
        check({tag, "_sel"}, 32'(cur_sel), 32'(exp_sel));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        sel_req = 1'b0;
    endtask

    int exp_c[9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
    int exp_t[9] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        div_sel = '0;
        sel_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ack", 32'(sel_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(cur_sel), 32'd17);

        // Selection 0 from IDLE: clk_in/2, tick every second cycle.
        idle_select("sel0", 5'd0, 5'd0);
        en = 1'b1;
        cyc();
        check("sel0_entry_clk", 32'(clk_out), 32'd0);
        check("sel0_entry_ack", 32'(sel_ack), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("div2_clk", 32'(clk_out), 32'((i % 2) == 0));
            check("div2_tick", 32'(tick), 32'((i % 2) == 0));
        end
        en = 1'b0;
        cyc();
        check("div2_stop_clk", 32'(clk_out), 32'd0);
        cyc();
        check("div2_idle_clk", 32'(clk_out), 32'd0);
        check("div2_idle_tick", 32'(tick), 32'd0);

        // Selection 3, then request 1 during the second high cycle.
        idle_select("sel3", 5'd3, 5'd3);
        en = 1'b1;
        cyc();
        check("s3_entry", 32'(clk_out), 32'd0);
        expect_phase("s3_low", 1'b0, 7);
        cyc();
        check("s3_rise", 32'(clk_out), 32'd1);
        check("s3_tick", 32'(tick), 32'd1);
        cyc();
        check("s3_hi2", 32'(clk_out), 32'd1);
        check("s3_hi2_tick", 32'(tick), 32'd0);
        sel_req = 1'b1;
        div_sel = 5'd1;
        cyc();
        check("sw_busy", 32'(busy), 32'd1);
        check("sw_hi3", 32'(clk_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("sw_hi_hold", 32'(clk_out), 32'd1);
            check("sw_noack", 32'(sel_ack), 32'd0);
        end
        cyc();
        check("sw_fall", 32'(clk_out), 32'd0);
        check("sw_ack", 32'(sel_ack), 32'd1);
        check("sw_sel", 32'(cur_sel), 32'd1);
        check("sw_done", 32'(busy), 32'd0);
        sel_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("div4_clk", 32'(clk_out), 32'(exp_c[i]));
            check("div4_tick", 32'(tick), 32'(exp_t[i]));
            check("div4_noack", 32'(sel_ack), 32'd0);
        end

        // en dropped at the end of a low phase: no rise, straight to IDLE.
        en = 1'b0;
        cyc();
        check("lowdrop_clk", 32'(clk_out), 32'd0);
        check("lowdrop_tick", 32'(tick), 32'd0);
        cyc();
        check("lowdrop_idle", 32'(clk_out), 32'd0);

        // Selection 2, en dropped in the first high cycle: high still lasts 4.
        idle_select("sel2", 5'd2, 5'd2);
        en = 1'b1;
        cyc();
        check("s2_entry", 32'(clk_out), 32'd0);
        expect_phase("s2_low", 1'b0, 3);
        cyc();
        check("s2_rise", 32'(clk_out), 32'd1);
        check("s2_tick", 32'(tick), 32'd1);
        en = 1'b0;
        expect_phase("stop_hi", 1'b1, 3);
        cyc();
        check("stop_fall", 32'(clk_out), 32'd0);
        check("stop_tick", 32'(tick), 32'd0);
        expect_phase("stop_idle", 1'b0, 3);

        // STOP resumed by en before terminal count: phase timing undisturbed.
        en = 1'b1;
        cyc();
        check("rs_entry", 32'(clk_out), 32'd0);
        expect_phase("rs_low", 1'b0, 3);
        cyc();
        check("rs_rise", 32'(clk_out), 32'd1);
        en = 1'b0;
        cyc();
        check("rs_stop", 32'(clk_out), 32'd1);
        en = 1'b1;
        cyc();
        check("rs_resume", 32'(clk_out), 32'd1);
        cyc();
        check("rs_hi4", 32'(clk_out), 32'd1);
        cyc();
        check("rs_fall", 32'(clk_out), 32'd0);
        expect_phase("rs_low2", 1'b0, 3);
        cyc();
        check("rs_rise2", 32'(clk_out), 32'd1);
        check("rs_tick2", 32'(tick), 32'd1);

        // Oversized request saturates; second request while busy is ignored.
        sel_req = 1'b1;
        div_sel = 5'd25;
        cyc();
        check("sat_busy", 32'(busy), 32'd1);
        div_sel = 5'd4;
        cyc();
        check("sat_noack1", 32'(sel_ack), 32'd0);
        cyc();
        check("sat_noack2", 32'(sel_ack), 32'd0);
        check("sat_hi", 32'(clk_out), 32'd1);
        cyc();
        check("sat_ack", 32'(sel_ack), 32'd1);
        check("sat_sel", 32'(cur_sel), 32'd17);
        check("sat_fall", 32'(clk_out), 32'd0);
        sel_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("sat_one_ack", 32'(sel_ack), 32'd0);
            check("sat_keep_sel", 32'(cur_sel), 32'd17);
            check("sat_not_busy", 32'(busy), 32'd0);
        end

        // Async reset in a high phase with a request latched.
        en = 1'b0;
        cyc();
        check("ar_idle", 32'(clk_out), 32'd0);
        idle_select("sel1", 5'd1, 5'd1);
        en = 1'b1;
        cyc();
        check("ar_entry", 32'(clk_out), 32'd0);
        cyc();
        check("ar_low2", 32'(clk_out), 32'd0);
        cyc();
        check("ar_rise", 32'(clk_out), 32'd1);
        sel_req = 1'b1;
        div_sel = 5'd3;
        cyc();
        check("ar_busy", 32'(busy), 32'd1);
        check("ar_hi", 32'(clk_out), 32'd1);
        #2;
        rst     = 1'b1;
        sel_req = 1'b0;
        #1;
        check("ar_clk", 32'(clk_out), 32'd0);
        check("ar_busy0", 32'(busy), 32'd0);
        check("ar_sel", 32'(cur_sel), 32'd17);
        check("ar_ack", 32'(sel_ack), 32'd0);
        check("ar_tick", 32'(tick), 32'd0);
        cyc();
        check("ar_hold_ack", 32'(sel_ack), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("ar_post_ack", 32'(sel_ack), 32'd0);
            check("ar_post_busy", 32'(busy), 32'd0);
            check("ar_post_sel", 32'(cur_sel), 32'd17);
            check("ar_post_clk", 32'(clk_out), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
